aes_block_arb_mux: RTL
======================

Name: aes_block_arb_mux

Overview:
- Parametrised, registered N-to-1 selector for AES state/key blocks, with valid/ready handshake on every input channel and on the output.
- Sits between multiple block sources (plaintext in, round feedback, key schedule, test injection) and a single AES datapath consumer.
- Generalises the existing combinational 4:1 128-bit mux: any width, any channel count, a directed or round-robin selection mode, and an output pipeline register with backpressure.

Parameters:
- WIDTH, 128, data width of each channel in bits.
- NUM_CH, 4, number of input channels; must be 2 or more. Need not be a power of two.
- SEL_W, $clog2(NUM_CH), width of select and channel-ID signals. Derived; never overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- mode  input  1  0 = directed (use sel), 1 = round-robin.
- sel  input  SEL_W  channel to select in directed mode.
- in_data  input  NUM_CH*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NUM_CH  per-channel valid.
- in_ready  output  NUM_CH  per-channel ready; one-hot or zero.
- out_data  output  WIDTH  registered selected block.
- out_valid  output  1  out_data holds an untaken block.
- out_ready  input  1  consumer accepts out_data.
- out_ch  output  SEL_W  channel index that out_data came from.

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately):
  - out_valid=0, out_data=0, out_ch=0.
  - Round-robin pointer ptr=0.
  - in_ready=0 while rst_n is low.
- load = !out_valid || out_ready.
  - The output register is empty, or it is draining this cycle.
- Directed mode (mode=0):
  - Candidate is sel. Grant exists if sel < NUM_CH and in_valid[sel]=1.
  - sel >= NUM_CH never grants.
  - ptr is not modified.
- Round-robin mode (mode=1):
  - Scan channels ptr, ptr+1, ... ptr+NUM_CH-1, each index mod NUM_CH.
  - Grant goes to the first channel with in_valid=1.
  - On an accepted grant g, ptr <= (g+1) mod NUM_CH, wrapping correctly for a non-power-of-two NUM_CH.
- in_ready[g] = load && grant exists. All other in_ready bits are 0.
  - in_ready may depend combinationally on out_ready, mode, sel and in_valid.
- Transfer on channel g occurs when in_valid[g] && in_ready[g]. On the next edge:
  - out_data <= channel g data.
  - out_ch <= g.
  - out_valid <= 1.
- Latency is exactly 1 cycle from input handshake to out_valid.
  - Full throughput: one block per cycle while out_ready=1 and a grant exists.
- Drain without refill: out_ready=1, out_valid=1, no grant → out_valid <= 0. out_data and out_ch keep their last value.
- Stall: out_valid=1 and out_ready=0.
  - out_data and out_ch are held stable; all in_ready are 0.
  - Changes on mode, sel or in_data do not disturb the held output.
- Mode switch:
  - Takes effect in the same cycle's arbitration.
  - ptr is retained across directed periods.
- Simultaneous drain and refill in one cycle: the new block replaces the old one, out_valid stays 1, no bubble.
- Reset asserted mid-stall: the held block is discarded, out_valid drops without waiting for the clock.
- No X propagation: unselected channels' data never reaches out_data.

Test Plan:
- Reset → out_valid=0, out_data=0, in_ready=0. Release rst_n, directed sel=2, in_valid=4'b0100, data2=128'hA5A5…, out_ready=1 → in_ready=4'b0100 in cycle 0; next cycle out_valid=1, out_data=A5A5…, out_ch=2.
- Round-robin, all four in_valid=1 held, out_ready=1 for 8 cycles → out_ch sequence 0,1,2,3,0,1,2,3, one block per cycle.
- Round-robin, in_valid=4'b1001 from ptr=1 → grant 3, then ptr=0 → grant 0, then grant 3.
- Backpressure: out_valid=1 with block B, out_ready=0 for 5 cycles while in_data and sel toggle → out_data=B and out_ch stable, in_ready=0; out_ready=1 → next queued block appears with no bubble.
- NUM_CH=3, WIDTH=32 instance, round-robin with all valid → out_ch wraps 0,1,2,0. Directed sel=3 → in_ready=0, out_valid falls after the drain.
- rst_n pulled low while out_valid=1 and out_ready=0 → out_valid=0 immediately, before the next clk edge. After release, ptr=0 and channel 0 has priority.

Source files
------------

// File: rtl/aes_block_arb_mux.sv
// aes_block_arb_mux: registered N-to-1 selector for AES state/key blocks.
// Each input channel and the output use a valid/ready handshake. A transfer
// happens on any edge where valid and ready are both high. Valid must not
// depend on ready. Ready may depend combinationally on valid and on the
// downstream ready.
// mode=0 picks the channel named by sel. mode=1 round-robins from an
// internal pointer. The chosen block lands in the output register one cycle
// after its handshake.
module aes_block_arb_mux #(
  parameter int WIDTH  = 128,
  parameter int NUM_CH = 4,
  // Derived from NUM_CH; leave at its default.
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SEL_W-1:0]        out_ch
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SEL_W-1:0] out_ch_q,    out_ch_d;
  logic [SEL_W-1:0] ptr_q,       ptr_d;

  logic             load;
  logic             grant_vld;
  logic [SEL_W-1:0] grant_id;
  logic [WIDTH-1:0] grant_data;

  // Channel index reached k steps after p, wrapping at NUM_CH. NUM_CH need
  // not be a power of two, so the wrap is explicit.
  function automatic int rr_index(input logic [SEL_W-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NUM_CH) s = s - NUM_CH;
    return s;
  endfunction

  // The output register can take a new block when it is empty or draining.
  assign load = !out_valid_q || out_ready;

  // Arbitration: pick the granted channel for this cycle.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    if (!mode) begin
      // A sel value of NUM_CH or more matches no channel, so it never grants.
      for (int i = 0; i < NUM_CH; i++) begin
        if (sel == SEL_W'(i) && in_valid[i]) begin
          grant_vld = 1'b1;
          grant_id  = SEL_W'(i);
        end
      end
    end else begin
      // Scan from the farthest position back toward ptr. The last hit
      // written is the nearest valid channel at or after ptr.
      for (int k = NUM_CH - 1; k >= 0; k--) begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (in_valid[i] && i == rr_index(ptr_q, k)) begin
            grant_vld = 1'b1;
            grant_id  = SEL_W'(i);
          end
        end
      end
    end
  end

  // Data mux. Only the granted channel's bits can reach the output register.
  always_comb begin
    grant_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant_vld && grant_id == SEL_W'(i)) begin
        grant_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Ready back to the sources: one-hot on the granted channel when the output
  // can load. It is forced low while reset is asserted.
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rst_n && load && grant_vld && grant_id == SEL_W'(i)) begin
        in_ready[i] = 1'b1;
      end
    end
  end

  // Next-state logic for the output register and the round-robin pointer.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    ptr_d       = ptr_q;
    if (load) begin
      // When no grant exists the output drains, but data and channel ID
      // keep their last values.
      out_valid_d = grant_vld;
      if (grant_vld) begin
        out_data_d = grant_data;
        out_ch_d   = grant_id;
        if (mode) begin
          ptr_d = (grant_id == SEL_W'(NUM_CH - 1)) ? '0 : grant_id + SEL_W'(1);
        end
      end
    end
  end

  // State registers. Asynchronous reset drops any held block immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule
